// File: rtl/alu_pkg.sv
// Shared definitions for the ALU result stage: function codes and FSM state encoding.
package alu_pkg;

  localparam logic [5:0] FN_AND   = 6'b100100;
  localparam logic [5:0] FN_OR    = 6'b100101;
  localparam logic [5:0] FN_ADD   = 6'b100000;
  localparam logic [5:0] FN_SUB   = 6'b100010;
  localparam logic [5:0] FN_SLT   = 6'b101010;
  localparam logic [5:0] FN_SRL   = 6'b000010;
  localparam logic [5:0] FN_MULTU = 6'b011001;
  localparam logic [5:0] FN_MFHI  = 6'b010000;
  localparam logic [5:0] FN_MFLO  = 6'b010010;

  typedef enum logic {
    IDLE = 1'b0,
    MUL  = 1'b1
  } state_e;

endpackage

// File: rtl/alu_shift_add_mul.sv
// Unsigned shift-add multiplier datapath: one partial-product step per cycle,
// exposing the next product value so the final step can be captured directly.
module alu_shift_add_mul #(
  parameter int WIDTH = 32,
  localparam int SHW = $clog2(WIDTH)
) (
  input  logic               clk,
  input  logic               reset_i,
  input  logic               load_i,
  input  logic               step_i,
  input  logic [WIDTH-1:0]   mcand_i,
  input  logic [WIDTH-1:0]   mplr_i,
  output logic [2*WIDTH-1:0] productNext_o,
  output logic               last_o
);

  logic [WIDTH-1:0]   mcandQ;
  logic [2*WIDTH-1:0] prodQ;
  logic [SHW-1:0]     countQ;
  logic [WIDTH:0]     sum;

  // Upper half accumulates; the multiplier shifts out of the lower half one bit per step.
  always_comb begin
    sum = {1'b0, prodQ[2*WIDTH-1:WIDTH]} + {1'b0, (prodQ[0] ? mcandQ : '0)};
    productNext_o = {sum, prodQ[WIDTH-1:1]};
  end

  assign last_o = (countQ == SHW'(WIDTH - 1));

  always_ff @(posedge clk) begin
    if (reset_i) begin
      mcandQ <= '0;
      prodQ  <= '0;
      countQ <= '0;
    end else if (load_i) begin
      mcandQ <= mcand_i;
      prodQ  <= {{WIDTH{1'b0}}, mplr_i};
      countQ <= '0;
    end else if (step_i) begin
      prodQ  <= productNext_o;
      countQ <= countQ + SHW'(1);
    end
  end

endmodule

// File: rtl/alu_result_unit.sv
// Registered ALU result stage: single-cycle logic/arith/shift ops, multi-cycle MULTU
// into HI/LO, MFHI/MFLO reads and a start/busy/done handshake.
module alu_result_unit
  import alu_pkg::*;
#(
  parameter int WIDTH = 32,
  localparam int SHW = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             Reset,
  input  logic             start,
  input  logic [5:0]       Signal,
  input  logic [WIDTH-1:0] dataA,
  input  logic [WIDTH-1:0] dataB,
  input  logic [SHW-1:0]   shamt,
  output logic [WIDTH-1:0] dataOut,
  output logic             zero,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             busy,
  output logic             done
);

  state_e           stateQ, stateD;
  logic [WIDTH-1:0] dataOutQ, dataOutD;
  logic [WIDTH-1:0] hiQ, hiD, loQ, loD;
  logic             zeroQ, doneQ, doneD;
  logic             mulLoad, mulStep, mulLast;
  logic [2*WIDTH-1:0] mulProduct;
  logic [WIDTH-1:0] diff, opResult;
  logic             overflow, less;

  alu_shift_add_mul #(.WIDTH(WIDTH)) uMul (
    .clk           (clk),
    .reset_i       (Reset),
    .load_i        (mulLoad),
    .step_i        (mulStep),
    .mcand_i       (dataA),
    .mplr_i        (dataB),
    .productNext_o (mulProduct),
    .last_o        (mulLast)
  );

  // Signed less-than from the subtraction sign corrected by two's-complement overflow.
  always_comb begin
    diff     = dataA - dataB;
    overflow = (dataA[WIDTH-1] ^ dataB[WIDTH-1]) & (diff[WIDTH-1] ^ dataA[WIDTH-1]);
    less     = diff[WIDTH-1] ^ overflow;
    opResult = '0;
    case (Signal)
      FN_AND:  opResult = dataA & dataB;
      FN_OR:   opResult = dataA | dataB;
      FN_ADD:  opResult = dataA + dataB;
      FN_SUB:  opResult = diff;
      FN_SLT:  opResult = {{(WIDTH-1){1'b0}}, less};
      FN_SRL:  opResult = dataB >> shamt;
      FN_MFHI: opResult = hiQ;
      FN_MFLO: opResult = loQ;
      default: opResult = '0;
    endcase
  end

  always_comb begin
    stateD   = stateQ;
    dataOutD = dataOutQ;
    hiD      = hiQ;
    loD      = loQ;
    doneD    = 1'b0;
    mulLoad  = 1'b0;
    mulStep  = 1'b0;
    case (stateQ)
      IDLE: begin
        if (start) begin
          if (Signal == FN_MULTU) begin
            mulLoad = 1'b1;
            stateD  = MUL;
          end else begin
            dataOutD = opResult;
            doneD    = 1'b1;
          end
        end
      end
      MUL: begin
        mulStep = 1'b1;
        if (mulLast) begin
          {hiD, loD} = mulProduct;
          dataOutD   = mulProduct[WIDTH-1:0];
          doneD      = 1'b1;
          stateD     = IDLE;
        end
      end
      default: stateD = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (Reset) begin
      stateQ   <= IDLE;
      dataOutQ <= '0;
      hiQ      <= '0;
      loQ      <= '0;
      zeroQ    <= 1'b1;
      doneQ    <= 1'b0;
    end else begin
      stateQ   <= stateD;
      dataOutQ <= dataOutD;
      hiQ      <= hiD;
      loQ      <= loD;
      zeroQ    <= (dataOutD == '0);
      doneQ    <= doneD;
    end
  end

  assign dataOut = dataOutQ;
  assign zero    = zeroQ;
  assign hi      = hiQ;
  assign lo      = loQ;
  assign busy    = (stateQ == MUL);
  assign done    = doneQ;

endmodule

// File: tb/tb_alu_result_unit.sv
// Self-checking bench for alu_result_unit (WIDTH=32): directed corner cases plus
// randomized operations compared against a plain-arithmetic reference model.
module tb_alu_result_unit;

  localparam logic [5:0] C_AND = 6'b100100, C_OR = 6'b100101, C_ADD = 6'b100000,
                         C_SUB = 6'b100010, C_SLT = 6'b101010, C_SRL = 6'b000010,
                         C_MUL = 6'b011001, C_MFHI = 6'b010000, C_MFLO = 6'b010010;

  logic        clk = 1'b0;
  logic        Reset, start;
  logic [5:0]  Signal;
  logic [31:0] dataA, dataB;
  logic [4:0]  shamt;
  logic [31:0] dataOut, hi, lo;
  logic        zero, busy, done;

  int checks = 0;
  int errors = 0;
  logic [31:0] mHi = '0, mLo = '0;

  alu_result_unit #(.WIDTH(32)) dut (
    .clk(clk), .Reset(Reset), .start(start), .Signal(Signal),
    .dataA(dataA), .dataB(dataB), .shamt(shamt),
    .dataOut(dataOut), .zero(zero), .hi(hi), .lo(lo), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] refResult(input logic [5:0] op, input logic [31:0] a,
                                            input logic [31:0] b, input logic [4:0] sh);
    case (op)
      C_AND:  return a & b;
      C_OR:   return a | b;
      C_ADD:  return a + b;
      C_SUB:  return a - b;
      C_SLT:  return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      C_SRL:  return b >> sh;
      C_MFHI: return mHi;
      C_MFLO: return mLo;
      default: return 32'd0;
    endcase
  endfunction

  task automatic issue(input logic [5:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [4:0] sh);
    @(negedge clk);
    start = 1'b1; Signal = op; dataA = a; dataB = b; shamt = sh;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  task automatic test_reset();
    Reset = 1'b1; start = 1'b0; Signal = '0; dataA = '0; dataB = '0; shamt = '0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (dataOut !== 32'd0 || hi !== 32'd0 || lo !== 32'd0 || zero !== 1'b1 ||
        busy !== 1'b0 || done !== 1'b0) begin
      errors++;
      $display("[TB] FAIL reset_state got dataOut=%h hi=%h lo=%h zero=%b busy=%b done=%b want 0/0/0/1/0/0",
               dataOut, hi, lo, zero, busy, done);
    end
    @(negedge clk);
    Reset = 1'b0;
  endtask

  task automatic test_add();
    issue(C_ADD, 32'h7FFFFFFF, 32'h1, 5'd0);
    checks++;
    if (dataOut !== 32'h80000000 || done !== 1'b1 || busy !== 1'b0 || zero !== 1'b0) begin
      errors++;
      $display("[TB] FAIL add_overflow got dataOut=%h done=%b busy=%b zero=%b want 80000000/1/0/0",
               dataOut, done, busy, zero);
    end
    @(posedge clk); #1;
    checks++;
    if (done !== 1'b0 || busy !== 1'b0 || dataOut !== 32'h80000000) begin
      errors++;
      $display("[TB] FAIL add_hold got done=%b busy=%b dataOut=%h want 0/0/80000000", done, busy, dataOut);
    end
  endtask

  task automatic test_directed();
    logic [5:0]  ops[8];
    logic [31:0] as[8], bs[8], exps[8];
    logic [4:0]  shs[8];
    ops  = '{C_SUB, C_SLT, C_SLT, C_AND, 6'b111111, C_SRL, C_SRL, C_OR};
    as   = '{32'd5, 32'hFFFFFFFF, 32'h7FFFFFFF, 32'hF0F0, 32'h1234, 32'h0, 32'h0, 32'h00F0};
    bs   = '{32'd7, 32'd1, 32'h80000000, 32'hFF00, 32'h5678, 32'h80000000, 32'hA5A5_0001, 32'h0F00};
    shs  = '{5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd31, 5'd0, 5'd0};
    exps = '{32'hFFFFFFFE, 32'd1, 32'd0, 32'hF000, 32'd0, 32'd1, 32'hA5A5_0001, 32'h0FF0};
    for (int i = 0; i < 8; i++) begin
      issue(ops[i], as[i], bs[i], shs[i]);
      checks++;
      if (dataOut !== exps[i] || done !== 1'b1 || zero !== (exps[i] == 32'd0)) begin
        errors++;
        $display("[TB] FAIL directed_%0d op=%b got dataOut=%h done=%b zero=%b want %h/1/%b",
                 i, ops[i], dataOut, done, zero, exps[i], exps[i] == 32'd0);
      end
    end
  endtask

  task automatic run_multu(input string name, input logic [31:0] a, input logic [31:0] b);
    logic [63:0] p;
    int n, busyCycles;
    bit seen;
    p = {32'd0, a} * {32'd0, b};
    issue(C_MUL, a, b, 5'd0);
    busyCycles = busy ? 1 : 0;
    checks++;
    if (busy !== 1'b1 || done !== 1'b0) begin
      errors++;
      $display("[TB] FAIL %s_start got busy=%b done=%b want 1/0", name, busy, done);
    end
    n = 0; seen = 0;
    while (n < 100 && !seen) begin
      @(posedge clk); #1;
      n++;
      if (done) seen = 1;
      else if (busy) busyCycles++;
    end
    checks++;
    if (!seen || n != 32 || busyCycles != 32 || busy !== 1'b0) begin
      errors++;
      $display("[TB] FAIL %s_timing got seen=%0d doneAfter=%0d busyCycles=%0d busy=%b want 1/32/32/0",
               name, seen, n, busyCycles, busy);
    end
    checks++;
    if (hi !== p[63:32] || lo !== p[31:0] || dataOut !== p[31:0]) begin
      errors++;
      $display("[TB] FAIL %s_result got hi=%h lo=%h dataOut=%h want %h/%h/%h",
               name, hi, lo, dataOut, p[63:32], p[31:0], p[31:0]);
    end
    mHi = p[63:32]; mLo = p[31:0];
    @(posedge clk); #1;
    checks++;
    if (done !== 1'b0) begin
      errors++;
      $display("[TB] FAIL %s_done_pulse got done=%b want 0", name, done);
    end
  endtask

  task automatic test_multu_and_moves();
    run_multu("multu_max", 32'hFFFFFFFF, 32'hFFFFFFFF);
    issue(C_MFHI, 32'h0, 32'h0, 5'd0);
    checks++;
    if (dataOut !== 32'hFFFFFFFE || done !== 1'b1) begin
      errors++;
      $display("[TB] FAIL mfhi got %h done=%b want fffffffe/1", dataOut, done);
    end
    issue(C_MFLO, 32'h0, 32'h0, 5'd0);
    checks++;
    if (dataOut !== 32'h00000001 || done !== 1'b1) begin
      errors++;
      $display("[TB] FAIL mflo got %h done=%b want 00000001/1", dataOut, done);
    end
  endtask

  task automatic test_busy_ignore();
    logic [63:0] p;
    int pulses, pulseAt;
    p = {32'd0, 32'h1234_5678} * {32'd0, 32'h9ABC_DEF0};
    issue(C_MUL, 32'h1234_5678, 32'h9ABC_DEF0, 5'd0);
    pulses = 0; pulseAt = -1;
    for (int c = 1; c <= 45; c++) begin
      if (c == 5) begin
        @(negedge clk);
        start = 1'b1; Signal = C_ADD; dataA = 32'd1; dataB = 32'd2;
        @(posedge clk); #1;
        start = 1'b0;
      end else begin
        @(posedge clk); #1;
      end
      if (done) begin
        pulses++;
        pulseAt = c;
      end
    end
    checks++;
    if (pulses != 1 || pulseAt != 32) begin
      errors++;
      $display("[TB] FAIL busy_ignore_pulses got count=%0d at=%0d want 1 at 32", pulses, pulseAt);
    end
    checks++;
    if (hi !== p[63:32] || lo !== p[31:0] || dataOut !== p[31:0]) begin
      errors++;
      $display("[TB] FAIL busy_ignore_result got hi=%h lo=%h dataOut=%h want %h/%h/%h",
               hi, lo, dataOut, p[63:32], p[31:0], p[31:0]);
    end
    mHi = p[63:32]; mLo = p[31:0];
  endtask

  task automatic test_reset_abort();
    int pulses;
    issue(C_MUL, 32'hDEAD_BEEF, 32'h0BAD_F00D, 5'd0);
    repeat (9) @(posedge clk);
    @(negedge clk);
    Reset = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (busy !== 1'b0 || hi !== 32'd0 || lo !== 32'd0 || dataOut !== 32'd0 ||
        done !== 1'b0 || zero !== 1'b1) begin
      errors++;
      $display("[TB] FAIL reset_abort got busy=%b hi=%h lo=%h dataOut=%h done=%b zero=%b want 0/0/0/0/0/1",
               busy, hi, lo, dataOut, done, zero);
    end
    @(negedge clk);
    Reset = 1'b0;
    mHi = '0; mLo = '0;
    pulses = 0;
    for (int c = 0; c < 40; c++) begin
      @(posedge clk); #1;
      if (done || busy) pulses++;
    end
    checks++;
    if (pulses != 0) begin
      errors++;
      $display("[TB] FAIL reset_abort_quiet got %0d done/busy cycles want 0", pulses);
    end
    run_multu("multu_3x4", 32'd3, 32'd4);
  endtask

  task automatic test_back_to_back();
    logic [5:0]  op;
    logic [31:0] a, b, exp;
    logic [4:0]  sh;
    logic [5:0]  seq[6];
    seq = '{C_ADD, C_SUB, C_MFHI, C_SRL, C_MFLO, C_SLT};
    for (int i = 0; i < 6; i++) begin
      op = seq[i]; a = $urandom; b = $urandom; sh = 5'($urandom_range(0, 31));
      exp = refResult(op, a, b, sh);
      @(negedge clk);
      start = 1'b1; Signal = op; dataA = a; dataB = b; shamt = sh;
      @(posedge clk); #1;
      checks++;
      if (dataOut !== exp || done !== 1'b1) begin
        errors++;
        $display("[TB] FAIL back_to_back_%0d op=%b got %h done=%b want %h/1", i, op, dataOut, done, exp);
      end
    end
    start = 1'b0;
    @(posedge clk); #1;
    checks++;
    if (done !== 1'b0) begin
      errors++;
      $display("[TB] FAIL back_to_back_end got done=%b want 0", done);
    end
  endtask

  task automatic test_random();
    logic [5:0]  codes[9];
    logic [5:0]  op;
    logic [31:0] a, b, exp;
    logic [4:0]  sh;
    codes = '{C_AND, C_OR, C_ADD, C_SUB, C_SLT, C_SRL, C_MFHI, C_MFLO, C_MUL};
    for (int i = 0; i < 60; i++) begin
      if ($urandom_range(0, 9) == 0) op = 6'($urandom);
      else op = codes[$urandom_range(0, 8)];
      a = $urandom; b = $urandom; sh = 5'($urandom_range(0, 31));
      if (i % 4 == 0) b = a;
      if (op == C_MUL) begin
        run_multu("multu_rand", a, b);
      end else begin
        exp = refResult(op, a, b, sh);
        issue(op, a, b, sh);
        checks++;
        if (dataOut !== exp || done !== 1'b1 || zero !== (exp == 32'd0)) begin
          errors++;
          $display("[TB] FAIL random_%0d op=%b a=%h b=%h sh=%0d got %h done=%b zero=%b want %h",
                   i, op, a, b, sh, dataOut, done, zero, exp);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_add();
    test_directed();
    test_multu_and_moves();
    test_busy_ignore();
    test_reset_abort();
    test_back_to_back();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
